bcd_clock_setter: RTL and testbench
===================================

# bcd_clock_setter

Time-set controller for the 4-digit BCD clock counter (M:C:D:U, per-digit limits 2/3/5/9). Three raw push-buttons drive an edit FSM: it freezes the counter, captures its current value into a shadow register, lets the user edit one digit at a time, then writes the result back with a one-cycle load strobe. It sits between the board buttons and the counter's pause/load inputs. It also drives a per-digit blink mask for the display.

## Interface

Parameters:
- F_CLK_HZ, 25_000_000: clock frequency.
- DEBOUNCE_MS, 20: required stable time before a button level is accepted.
- REPEAT_DELAY_MS, 600: hold time before auto-repeat starts (inc/dec only).
- REPEAT_RATE_MS, 150: auto-repeat period.
- BLINK_MS, 250: half-period of the selected-digit blink.
- TIMEOUT_S, 10: idle time in edit before the edit is abandoned.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high; clears all state.
- btn_mode, input, 1: raw, asynchronous, active-high.
- btn_inc, input, 1: raw, asynchronous, active-high.
- btn_dec, input, 1: raw, asynchronous, active-high.
- cur_m, cur_c, cur_d, cur_u, input, 4 each: live counter digits.
- hold, output, 1: pause request to the counter; 1 in every state except IDLE.
- load, output, 1: one-cycle strobe that writes load_* into the counter.
- load_m, load_c, load_d, load_u, output, 4 each: shadow digits, always driven.
- edit_sel, output, 2: selected digit (3=M, 2=C, 1=D, 0=U); 0 in IDLE.
- digit_on, output, 4: display enable per digit, [3]=M … [0]=U.

## Operation

- Button front end, one instance per button:
  - 2-FF synchronizer.
  - Debounce counter of DB_TKS = (F_CLK_HZ/1000)*DEBOUNCE_MS cycles. The accepted level changes only after the synchronized level has differed from it for DB_TKS consecutive cycles.
  - Press event: a one-cycle pulse on the accepted level's 0→1 edge.
  - Auto-repeat (inc and dec only): while the accepted level stays 1, an extra event fires after REPEAT_DELAY_MS from the press, then every REPEAT_RATE_MS. Repeat timing is in ticks derived the same way as DB_TKS.
- FSM states: IDLE, EDIT_M, EDIT_C, EDIT_D, EDIT_U, COMMIT.
- Mode events advance the FSM:
  - IDLE → EDIT_M, capturing the shadow from cur_*. Any captured digit above its limit is stored as 0.
  - EDIT_M → EDIT_C → EDIT_D → EDIT_U → COMMIT.
  - COMMIT lasts exactly 1 cycle with load=1, then returns to IDLE.
- Inc/dec events act only in EDIT_* states, on the selected shadow digit:
  - inc at the limit wraps to 0; dec at 0 wraps to the limit.
  - Limits: M=2, C=3, D=5, U=9.
- Simultaneous events in the same cycle:
  - mode together with inc or dec: mode wins, the other is dropped.
  - inc and dec together: both dropped.
- Timeout: any event restarts a TIMEOUT_S × F_CLK_HZ cycle timer. On expiry in an EDIT_* state the FSM goes straight to IDLE with no load pulse and the shadow discarded.
- digit_on:
  - IDLE and COMMIT: 4'b1111.
  - EDIT_*: non-selected digits 1. The selected digit toggles every BLINK_MS, starting "on".
  - The blink timer restarts on every state change and every inc/dec event, so the edited digit is shown immediately.
- Events in IDLE other than mode are ignored; the counter is never touched outside COMMIT.

## Timing

- Reset values: hold=0, load=0, load_*=0, edit_sel=0, digit_on=4'b1111, state IDLE, all timers and debouncers cleared (accepted level 0).
- Latency from raw button edge, assuming no bounce:
  - 2 sync cycles + DB_TKS cycles to the press event.
  - The FSM/shadow update is registered on the cycle after the event.
- hold:
  - rises in the same cycle the FSM enters EDIT_M;
  - stays 1 through COMMIT;
  - falls on the cycle after load, so the counter is still paused when it samples load.
- load_* are valid in the cycle load=1 and hold the shadow value afterwards.
- Reset asserted mid-edit: immediate asynchronous return to reset values; no load pulse.

## Test plan

Bench parameters: F_CLK_HZ=1000, i.e. 1 ms per cycle.

- **Full edit and commit.** cur=1,2,3,4. Steps: mode, inc, then mode ×4. Expected: hold=1 during edit; one load pulse with load_m=2, load_c=2, load_d=3, load_u=4; hold=0 the following cycle.
- **Wrap in both directions.** Shadow C=3: inc → 0, then dec → 3. Shadow D=0: dec → 5. Shadow U=9: inc → 0.
- **Bounce rejection.** btn_inc toggles every 5 ms for 50 ms, then holds high 30 ms, in EDIT_U with U=0. Expected: exactly one increment, 22 cycles after the last edge; U=1.
- **Auto-repeat.** btn_inc held for 1000 ms in EDIT_U from U=0. Expected: events at roughly 22, 622, 772, 922 ms; final U=4.
- **Timeout.** Enter edit, then no presses for 10 s. Expected: FSM back in IDLE, hold=0, load never pulses, digit_on=1111.
- **Async reset mid-edit.** Assert reset in EDIT_D. Expected: hold=0, edit_sel=0, digit_on=1111 without waiting for a clock edge; the next mode press recaptures cur_*.

Source files
------------

// File: rtl/bcd_clock_setter_if.sv
// Bus between the time-set controller, the board buttons, the counter and the display.
// master: controller side (buttons/cur_* in; hold/load/load_*/edit_sel/digit_on out).
interface bcd_clock_setter_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [3:0] cur_m;
  logic [3:0] cur_c;
  logic [3:0] cur_d;
  logic [3:0] cur_u;
  logic       hold;
  logic       load;
  logic [3:0] load_m;
  logic [3:0] load_c;
  logic [3:0] load_d;
  logic [3:0] load_u;
  logic [1:0] edit_sel;
  logic [3:0] digit_on;

  modport master (
    input  btn_mode, btn_inc, btn_dec,
    input  cur_m, cur_c, cur_d, cur_u,
    output hold, load,
    output load_m, load_c, load_d, load_u,
    output edit_sel, digit_on
  );

  modport slave (
    output btn_mode, btn_inc, btn_dec,
    output cur_m, cur_c, cur_d, cur_u,
    input  hold, load,
    input  load_m, load_c, load_d, load_u,
    input  edit_sel, digit_on
  );
endinterface

// File: rtl/bcd_clock_setter.sv
// Time-set controller for the M:C:D:U BCD clock: debounced buttons, edit FSM, shadow, blink.
// Ports: clk, reset (async, high), bus (master: buttons, cur_*, hold/load/load_*, edit_sel, digit_on).
module bcd_clock_setter_btn #(
  parameter int unsigned DB_TKS   = 20,
  parameter int unsigned DLY_TKS  = 600,
  parameter int unsigned RATE_TKS = 150,
  parameter bit          REPEAT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic ev
);
  logic        s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d;
  logic        first_q, first_d, ev_q, ev_d;
  logic [31:0] db_cnt_q, db_cnt_d, rpt_cnt_q, rpt_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      lvl_q     <= 1'b0;
      first_q   <= 1'b0;
      ev_q      <= 1'b0;
      db_cnt_q  <= '0;
      rpt_cnt_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      lvl_q     <= lvl_d;
      first_q   <= first_d;
      ev_q      <= ev_d;
      db_cnt_q  <= db_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    lvl_d     = lvl_q;
    first_d   = first_q;
    ev_d      = 1'b0;
    db_cnt_d  = '0;
    rpt_cnt_d = rpt_cnt_q;
    if (s2_q != lvl_q) begin
      if (db_cnt_q == DB_TKS - 1) begin
        lvl_d = s2_q;
        if (s2_q) begin
          ev_d      = 1'b1;
          rpt_cnt_d = '0;
          first_d   = 1'b1;
        end
      end else begin
        db_cnt_d = db_cnt_q + 32'd1;
      end
    end
    // First repeat waits the long delay, later ones the short rate.
    if (REPEAT && lvl_q && lvl_d) begin
      if (rpt_cnt_q == (first_q ? DLY_TKS : RATE_TKS) - 1) begin
        ev_d      = 1'b1;
        rpt_cnt_d = '0;
        first_d   = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 32'd1;
      end
    end
  end

  assign ev = ev_q;
endmodule

module bcd_clock_setter #(
  parameter int unsigned F_CLK_HZ        = 25_000_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 600,
  parameter int unsigned REPEAT_RATE_MS  = 150,
  parameter int unsigned BLINK_MS        = 250,
  parameter int unsigned TIMEOUT_S       = 10
) (
  input logic                clk,
  input logic                reset,
  bcd_clock_setter_if.master bus
);
  localparam int unsigned TPMS      = F_CLK_HZ / 1000;
  localparam int unsigned DB_TKS    = TPMS * DEBOUNCE_MS;
  localparam int unsigned DLY_TKS   = TPMS * REPEAT_DELAY_MS;
  localparam int unsigned RATE_TKS  = TPMS * REPEAT_RATE_MS;
  localparam int unsigned BLINK_TKS = TPMS * BLINK_MS;
  localparam int unsigned TO_TKS    = TIMEOUT_S * F_CLK_HZ;

  typedef enum logic [2:0] {
    IDLE, EDIT_M, EDIT_C, EDIT_D, EDIT_U, COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0][3:0]  sh_q, sh_d, cur;
  logic [31:0]      to_cnt_q, to_cnt_d, blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic             ev_mode, ev_inc, ev_dec, inc_ev, dec_ev, any_ev;
  logic             edit, to_exp, hold, load;
  logic [1:0]       sel;
  logic [3:0]       digit_on;

  function automatic logic [3:0] lim(input logic [1:0] i);
    unique case (i)
      2'd3:    lim = 4'd2;
      2'd2:    lim = 4'd3;
      2'd1:    lim = 4'd5;
      default: lim = 4'd9;
    endcase
  endfunction

  bcd_clock_setter_btn #(
    .DB_TKS(DB_TKS), .DLY_TKS(DLY_TKS),
    .RATE_TKS(RATE_TKS), .REPEAT(1'b0)
  ) u_mode (.clk(clk), .reset(reset), .raw(bus.btn_mode), .ev(ev_mode));

  bcd_clock_setter_btn #(
    .DB_TKS(DB_TKS), .DLY_TKS(DLY_TKS),
    .RATE_TKS(RATE_TKS), .REPEAT(1'b1)
  ) u_inc (.clk(clk), .reset(reset), .raw(bus.btn_inc), .ev(ev_inc));

  bcd_clock_setter_btn #(
    .DB_TKS(DB_TKS), .DLY_TKS(DLY_TKS),
    .RATE_TKS(RATE_TKS), .REPEAT(1'b1)
  ) u_dec (.clk(clk), .reset(reset), .raw(bus.btn_dec), .ev(ev_dec));

  // Mode beats inc/dec; inc with dec cancels both.
  assign inc_ev = ev_inc & ~ev_mode & ~ev_dec;
  assign dec_ev = ev_dec & ~ev_mode & ~ev_inc;
  assign any_ev = ev_mode | ev_inc | ev_dec;
  assign cur    = {bus.cur_m, bus.cur_c, bus.cur_d, bus.cur_u};
  assign to_exp = edit && (to_cnt_q == TO_TKS - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      to_cnt_q    <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ev_mode) state_d = EDIT_M;
      EDIT_M:  if (ev_mode) state_d = EDIT_C;
               else if (to_exp) state_d = IDLE;
      EDIT_C:  if (ev_mode) state_d = EDIT_D;
               else if (to_exp) state_d = IDLE;
      EDIT_D:  if (ev_mode) state_d = EDIT_U;
               else if (to_exp) state_d = IDLE;
      EDIT_U:  if (ev_mode) state_d = COMMIT;
               else if (to_exp) state_d = IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold     = (state_q != IDLE);
    load     = (state_q == COMMIT);
    edit     = 1'b0;
    sel      = 2'd0;
    unique case (state_q)
      EDIT_M:  begin edit = 1'b1; sel = 2'd3; end
      EDIT_C:  begin edit = 1'b1; sel = 2'd2; end
      EDIT_D:  begin edit = 1'b1; sel = 2'd1; end
      EDIT_U:  begin edit = 1'b1; sel = 2'd0; end
      default: begin edit = 1'b0; sel = 2'd0; end
    endcase
    digit_on = 4'hf;
    if (edit && !blink_on_q) digit_on[sel] = 1'b0;
  end

  always_comb begin
    sh_d        = sh_q;
    to_cnt_d    = '0;
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (state_q == IDLE && ev_mode) begin
      for (int i = 0; i < 4; i++)
        sh_d[i] = (cur[i] > lim(2'(i))) ? 4'd0 : cur[i];
    end else if (edit && inc_ev) begin
      sh_d[sel] = (sh_q[sel] == lim(sel)) ? 4'd0 : sh_q[sel] + 4'd1;
    end else if (edit && dec_ev) begin
      sh_d[sel] = (sh_q[sel] == 4'd0) ? lim(sel) : sh_q[sel] - 4'd1;
    end
    if (edit && !any_ev) to_cnt_d = to_cnt_q + 32'd1;
    // Restarting the blink keeps the freshly edited digit visible.
    if (state_d == state_q && edit && !inc_ev && !dec_ev) begin
      if (blink_cnt_q == BLINK_TKS - 1) begin
        blink_on_d = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        blink_on_d  = blink_on_q;
      end
    end
  end

  assign bus.hold     = hold;
  assign bus.load     = load;
  assign bus.load_m   = sh_q[3];
  assign bus.load_c   = sh_q[2];
  assign bus.load_d   = sh_q[1];
  assign bus.load_u   = sh_q[0];
  assign bus.edit_sel = sel;
  assign bus.digit_on = digit_on;
endmodule

// File: tb/tb_bcd_clock_setter.sv
// Directed bench for bcd_clock_setter at 1 kHz (1 cycle = 1 ms).
// Covers reset, full edit/commit, wraps, bounce, auto-repeat, timeout, async reset.
`timescale 1ns/1ps
module tb_bcd_clock_setter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   load_cnt = 0;

  bcd_clock_setter_if bus();

  bcd_clock_setter #(.F_CLK_HZ(1000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.load === 1'b1) load_cnt <= load_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] shd();
    return {bus.load_m, bus.load_c, bus.load_d, bus.load_u};
  endfunction

  task automatic set_cur(input logic [15:0] v);
    {bus.cur_m, bus.cur_c, bus.cur_d, bus.cur_u} = v;
  endtask

  // 0 = mode, 1 = inc, 2 = dec
  task automatic press(input int b);
    if (b == 0) bus.btn_mode = 1'b1;
    else if (b == 1) bus.btn_inc = 1'b1;
    else bus.btn_dec = 1'b1;
    cyc(40);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    cyc(40);
  endtask

  task automatic commit(input logic [15:0] exp);
    logic found;
    found = 1'b0;
    bus.btn_mode = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc(1);
      if (bus.load === 1'b1) found = 1'b1;
    end
    chk("commit_seen", 16'(found), 16'd1);
    if (found) begin
      chk("load_val", shd(), exp);
      chk("hold_at_load", 16'(bus.hold), 16'd1);
      cyc(1);
      chk("hold_after_load", 16'(bus.hold), 16'd0);
      chk("load_one_cycle", 16'(bus.load), 16'd0);
    end
    bus.btn_mode = 1'b0;
    cyc(40);
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    set_cur(16'h0000);
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_hold", 16'(bus.hold), 16'd0);
    chk("rst_load", 16'(bus.load), 16'd0);
    chk("rst_sel", 16'(bus.edit_sel), 16'd0);
    chk("rst_digit_on", 16'(bus.digit_on), 16'hf);
    chk("rst_shadow", shd(), 16'h0000);

    // Full edit and commit
    set_cur(16'h1234);
    press(0);
    chk("e1_sel_m", 16'(bus.edit_sel), 16'd3);
    chk("e1_hold", 16'(bus.hold), 16'd1);
    chk("e1_capture", shd(), 16'h1234);
    press(1);
    chk("e1_inc_m", shd(), 16'h2234);
    press(0);
    chk("e1_sel_c", 16'(bus.edit_sel), 16'd2);
    press(0);
    chk("e1_sel_d", 16'(bus.edit_sel), 16'd1);
    press(0);
    chk("e1_sel_u", 16'(bus.edit_sel), 16'd0);
    chk("e1_hold_u", 16'(bus.hold), 16'd1);
    commit(16'h2234);
    chk("e1_idle_sel", 16'(bus.edit_sel), 16'd0);
    chk("e1_load_cnt", 16'(load_cnt), 16'd1);

    // Wraps in both directions, blink
    set_cur(16'h2309);
    press(0);
    press(0);
    press(1);
    chk("wrap_c_inc", shd(), 16'h2009);
    press(2);
    chk("wrap_c_dec", shd(), 16'h2309);
    press(0);
    press(2);
    chk("wrap_d_dec", shd(), 16'h2359);
    press(0);
    press(1);
    chk("wrap_u_inc", shd(), 16'h2350);
    chk("blink_on", 16'(bus.digit_on), 16'hf);
    cyc(250);
    chk("blink_off", 16'(bus.digit_on), 16'he);
    commit(16'h2350);
    chk("wrap_load_cnt", 16'(load_cnt), 16'd2);

    // Clamp on capture, async reset mid-edit
    set_cur(16'h4979);
    press(0);
    chk("clamp_capture", shd(), 16'h0009);
    press(0);
    press(0);
    chk("ar_sel_d", 16'(bus.edit_sel), 16'd1);
    reset = 1'b1;
    #2;
    chk("ar_hold", 16'(bus.hold), 16'd0);
    chk("ar_sel", 16'(bus.edit_sel), 16'd0);
    chk("ar_digit_on", 16'(bus.digit_on), 16'hf);
    chk("ar_shadow", shd(), 16'h0000);
    reset = 1'b0;
    cyc(2);
    set_cur(16'h1234);
    press(0);
    chk("ar_recapture", shd(), 16'h1234);
    chk("ar_sel_m", 16'(bus.edit_sel), 16'd3);

    // Timeout
    cyc(9000);
    chk("to_still_edit", 16'(bus.hold), 16'd1);
    cyc(1100);
    chk("to_hold", 16'(bus.hold), 16'd0);
    chk("to_sel", 16'(bus.edit_sel), 16'd0);
    chk("to_digit_on", 16'(bus.digit_on), 16'hf);
    chk("to_no_load", 16'(load_cnt), 16'd2);

    // Bounce rejection in EDIT_U
    set_cur(16'h1230);
    press(0);
    press(0);
    press(0);
    press(0);
    chk("b_sel_u", 16'(bus.edit_sel), 16'd0);
    chk("b_hold", 16'(bus.hold), 16'd1);
    for (int i = 0; i < 10; i++) begin
      bus.btn_inc = (i % 2 == 0);
      cyc(5);
    end
    bus.btn_inc = 1'b1;
    cyc(22);
    chk("b_before_evt", shd(), 16'h1230);
    cyc(1);
    chk("b_one_inc", shd(), 16'h1231);
    cyc(7);
    bus.btn_inc = 1'b0;
    cyc(40);
    chk("b_final", shd(), 16'h1231);

    // Auto-repeat from U=0
    press(2);
    chk("r_start", shd(), 16'h1230);
    bus.btn_inc = 1'b1;
    cyc(600);
    chk("r_600ms", shd(), 16'h1231);
    cyc(400);
    chk("r_1000ms", shd(), 16'h1234);
    bus.btn_inc = 1'b0;
    cyc(40);
    chk("r_final", shd(), 16'h1234);
    commit(16'h1234);
    chk("r_load_cnt", 16'(load_cnt), 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
